// File: rtl/fixed_to_float_packer.sv
// Serial fixed-point to packed-float converter: takes |x|, normalises one bit
// per cycle, then rounds to nearest-even and emits {sign, exponent, mantissa}.
module fixed_to_float_packer #(
  parameter int montissa_length           = 23,
  parameter int number_of_integer         = 12,
  parameter int number_of_floating_points = 12
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic                                                start,
  input  logic [number_of_integer+number_of_floating_points-1:0] fixed_in,
  output logic                                                ready,
  output logic                                                valid,
  output logic [montissa_length+8:0]                          out
);

  localparam int W  = number_of_integer + number_of_floating_points;
  localparam int ML = montissa_length;

  // Exponent of bit W-1; the exponent never leaves 1..254, so 8 bits suffice.
  localparam logic [7:0] EXP_INIT = 8'(number_of_integer + 126);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] NORMALIZE = 2'd1;
  localparam logic [1:0] ROUND     = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  mag;
  logic [7:0]    exp;
  logic          sign;
  logic          zero;

  logic [W-1:0]  abs_in;
  logic [ML-1:0] mant_raw;
  logic          guard;
  logic          sticky;
  logic          inc;
  logic          carry;
  logic [ML-1:0] mant_rnd;
  logic [7:0]    exp_rnd;

  assign abs_in = fixed_in[W-1] ? (~fixed_in + W'(1)) : fixed_in;
  assign ready  = (state == IDLE);

  // Split the bits below the hidden one into kept mantissa, guard and sticky.
  generate
    if (W == 1) begin : g_no_frac
      assign mant_raw = '0;
      assign guard    = 1'b0;
      assign sticky   = 1'b0;
    end else if (W - 1 <= ML) begin : g_pad
      assign mant_raw = ML'(mag[W-2:0]) << (ML - (W - 1));
      assign guard    = 1'b0;
      assign sticky   = 1'b0;
    end else begin : g_trunc
      localparam logic [W-2:0] LOW_MASK = {(W-1){1'b1}} >> (ML + 1);
      assign mant_raw = mag[W-2 -: ML];
      assign guard    = mag[W-2-ML];
      assign sticky   = |(mag[W-2:0] & LOW_MASK);
    end
  endgenerate

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    inc               = guard & (sticky | mant_raw[0]);
    {carry, mant_rnd} = {1'b0, mant_raw} + {{ML{1'b0}}, inc};
    exp_rnd           = exp + {7'd0, carry};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mag   <= '0;
      exp   <= '0;
      sign  <= 1'b0;
      zero  <= 1'b0;
      valid <= 1'b0;
      out   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= fixed_in[W-1];
            mag   <= abs_in;
            exp   <= EXP_INIT;
            zero  <= (abs_in == '0);
            state <= (abs_in == '0) ? ROUND : NORMALIZE;
          end
        end
        NORMALIZE: begin
          if (mag[W-1]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        ROUND: begin
          // A zero sample always yields +0, never -0.
          out   <= zero ? '0 : {sign, exp_rnd, mant_rnd};
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float_packer.sv
// Self-checking bench: default-width converter plus a 10-bit-mantissa instance,
// directed and random samples checked against an arithmetic reference model.
module tb_fixed_to_float_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [23:0] fixed_a, fixed_b;
  logic        ready_a, valid_a, ready_b, valid_b;
  logic [31:0] out_a;
  logic [18:0] out_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fixed_to_float_packer dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .fixed_in(fixed_a),
    .ready(ready_a), .valid(valid_a), .out(out_a)
  );

  fixed_to_float_packer #(
    .montissa_length(10), .number_of_integer(12), .number_of_floating_points(12)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .fixed_in(fixed_b),
    .ready(ready_b), .valid(valid_b), .out(out_b)
  );

  // Reference: value = x * 2^-12, find leading one, round remainder to nearest-even.
  function automatic void ref_model(input int ml, input logic [23:0] x,
                                    output logic [63:0] word, output int lat);
    longint m, rem, q, r, half;
    int     p, e, sh;
    bit     s;
    s = x[23];
    m = s ? ((longint'(1) << 24) - longint'(x)) : longint'(x);
    word = '0;
    lat  = 1;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < 25; i++) if (m >= (longint'(1) << i)) p = i;
    e   = 127 + p - 12;
    rem = m - (longint'(1) << p);
    if (p <= ml) begin
      q = rem << (ml - p);
    end else begin
      sh   = p - ml;
      q    = rem >> sh;
      r    = rem - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
    end
    if (q == (longint'(1) << ml)) begin
      q = 0;
      e = e + 1;
    end
    word = (64'(s) << (ml + 8)) | (64'(e) << ml) | 64'(q);
    lat  = 25 - p;
  endfunction

  // Issue one request and wait (bounded) for its result.
  task automatic run_conv(input bit sel, input logic [23:0] x,
                          output logic [63:0] res, output int lat, output bit ready_ok);
    res = '0; lat = -1; ready_ok = 1'b1;
    @(negedge clk);
    if (sel) begin start_b = 1'b1; fixed_b = x; end
    else     begin start_a = 1'b1; fixed_a = x; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    if (sel ? ready_b : ready_a) ready_ok = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (sel ? valid_b : valid_a) begin
        lat = i;
        res = sel ? 64'(out_b) : 64'(out_a);
        break;
      end
      if (sel ? ready_b : ready_a) ready_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({ready_a, valid_a, out_a} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_a: ready=%b valid=%b out=%h, want 1 0 0", ready_a, valid_a, out_a);
    end
    n_cmp++;
    if ({ready_b, valid_b, out_b} !== {1'b1, 1'b0, 19'h0}) begin
      n_bad++; $display("FAIL reset_b: ready=%b valid=%b out=%h, want 1 0 0", ready_b, valid_b, out_b);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_directed_default;
    logic [23:0] xs [4]   = '{24'h001000, 24'hFFD800, 24'h800000, 24'h000001};
    logic [31:0] want [4] = '{32'h3F800000, 32'hC0200000, 32'hC5000000, 32'h39800000};
    int          lats [4] = '{13, 12, 2, 25};
    logic [63:0] res; int lat; bit rok;
    for (int i = 0; i < 4; i++) begin
      run_conv(1'b0, xs[i], res, lat, rok);
      n_cmp++;
      if (res !== 64'(want[i])) begin
        n_bad++; $display("FAIL dir_out x=%h: got %h want %h", xs[i], res, want[i]);
      end
      n_cmp++;
      if (lat !== lats[i]) begin
        n_bad++; $display("FAIL dir_lat x=%h: got %0d want %0d", xs[i], lat, lats[i]);
      end
      n_cmp++;
      if (rok !== 1'b1) begin
        n_bad++; $display("FAIL dir_ready x=%h: ready seen high while busy", xs[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({valid_a, out_a} !== {1'b0, 32'h39800000}) begin
      n_bad++; $display("FAIL hold: valid=%b out=%h want 0 39800000", valid_a, out_a);
    end
  endtask

  task automatic test_rounding;
    logic [23:0] xs [4]   = '{24'h7FFFFF, 24'h001002, 24'h001003, 24'h001006};
    logic [18:0] want [4] = '{19'h22800, 19'h1FC00, 19'h1FC01, 19'h1FC02};
    int          lats [4] = '{3, 13, 13, 13};
    logic [63:0] res; int lat; bit rok;
    for (int i = 0; i < 4; i++) begin
      run_conv(1'b1, xs[i], res, lat, rok);
      n_cmp++;
      if (res !== 64'(want[i]) || lat !== lats[i]) begin
        n_bad++;
        $display("FAIL round x=%h: got %h lat %0d want %h lat %0d", xs[i], res, lat, want[i], lats[i]);
      end
    end
  endtask

  task automatic test_zero_back_to_back;
    logic [63:0] res; int lat; bit rok;
    run_conv(1'b0, 24'h000000, res, lat, rok);
    n_cmp++;
    if (res !== 64'h0 || lat !== 1 || ready_a !== 1'b1) begin
      n_bad++; $display("FAIL zero: got %h lat %0d ready %b want 0 lat 1 ready 1", res, lat, ready_a);
    end
    start_a = 1'b1; fixed_a = 24'h001000;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_cmp++;
    if (ready_a !== 1'b0 || valid_a !== 1'b0) begin
      n_bad++; $display("FAIL b2b_accept: ready=%b valid=%b want 0 0", ready_a, valid_a);
    end
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (valid_a) begin lat = i; break; end
    end
    n_cmp++;
    if (lat !== 13 || out_a !== 32'h3F800000) begin
      n_bad++; $display("FAIL b2b_result: got %h lat %0d want 3F800000 lat 13", out_a, lat);
    end
  endtask

  task automatic test_async_reset;
    int seen = 0;
    logic [63:0] res; int lat; bit rok;
    @(negedge clk); start_a = 1'b1; fixed_a = 24'h000001;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ready_a, valid_a, out_a} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL async_reset: ready=%b valid=%b out=%h want 1 0 0", ready_a, valid_a, out_a);
    end
    @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid_a) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL reset_discard: got %0d valid pulses want 0", seen);
    end
    run_conv(1'b0, 24'hFFD800, res, lat, rok);
    n_cmp++;
    if (res !== 64'hC0200000 || lat !== 12) begin
      n_bad++; $display("FAIL post_reset: got %h lat %0d want C0200000 lat 12", res, lat);
    end
  endtask

  task automatic test_start_held;
    int nval = 0, first = -1, second = -1;
    logic rdy14 = 1'b1;
    logic [31:0] res2 = '0;
    @(negedge clk); start_a = 1'b1; fixed_a = 24'h001000;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 14) rdy14 = ready_a;
      if (i == 20) start_a = 1'b0;
      if (valid_a) begin
        if (i <= 20) begin nval++; first = i; end
        else if (second < 0) begin second = i; res2 = out_a; end
      end
    end
    n_cmp++;
    if (nval !== 1 || first !== 13) begin
      n_bad++; $display("FAIL held_first: got %0d pulses at %0d want 1 at 13", nval, first);
    end
    n_cmp++;
    if (rdy14 !== 1'b0) begin
      n_bad++; $display("FAIL held_accept: ready after valid cycle=%b want 0", rdy14);
    end
    n_cmp++;
    if (second !== 27 || res2 !== 32'h3F800000) begin
      n_bad++; $display("FAIL held_second: got %h at %0d want 3F800000 at 27", res2, second);
    end
  endtask

  task automatic test_random;
    logic [23:0] x; logic [63:0] res, want; int lat, want_lat; bit rok;
    for (int n = 0; n < 60; n++) begin
      bit sel = (n % 2) == 1;
      x = 24'($urandom >> $urandom_range(0, 24));
      if ($urandom_range(0, 1) == 1) x = ~x + 24'd1;
      if ($urandom_range(0, 15) == 0) x = 24'h000000;
      ref_model(sel ? 10 : 23, x, want, want_lat);
      run_conv(sel, x, res, lat, rok);
      n_cmp++;
      if (res !== want) begin
        n_bad++; $display("FAIL rand_out ml=%0d x=%h: got %h want %h", sel ? 10 : 23, x, res, want);
      end
      n_cmp++;
      if (lat !== want_lat || rok !== 1'b1) begin
        n_bad++; $display("FAIL rand_lat x=%h: got %0d ready_ok %b want %0d 1", x, lat, rok, want_lat);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    fixed_a = '0;   fixed_b = '0;
    test_reset;
    test_directed_default;
    test_rounding;
    test_zero_back_to_back;
    test_async_reset;
    test_start_held;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
